// File: rtl/dmem_pkg.sv
// rtl/dmem_pkg.sv - shared types and constants for the data-memory controller
package dmem_pkg;

   typedef enum logic [1:0] {IDLE, WAIT, ACCESS, DONE} dmem_state_t;
   typedef enum logic {OP_RD, OP_WR} dmem_op_t;

   // Byte-address bit where the word index starts
   localparam int ADDR_LSB = 2;

endpackage

// File: rtl/data_mem_ctrl_if.sv
// rtl/data_mem_ctrl_if.sv - core-to-data-memory word access bus
interface data_mem_ctrl_if;

   logic        MemRead;
   logic        MemWrite;
   logic [31:0] dAddress;
   logic [31:0] dWriteData;
   logic [31:0] dReadData;
   logic        dReady;
   logic        dError;
   logic        dBusy;

   // Core side drives requests and receives completion
   modport master (
      output MemRead, MemWrite, dAddress, dWriteData,
      input  dReadData, dReady, dError, dBusy
   );

   // Memory controller side
   modport slave (
      input  MemRead, MemWrite, dAddress, dWriteData,
      output dReadData, dReady, dError, dBusy
   );

endinterface

// File: rtl/dmem_array.sv
// rtl/dmem_array.sv - single-port synchronous word RAM with registered read port
module dmem_array #(
   parameter int DEPTH_WORDS = 1024
) (
   input  logic                           clk,
   input  logic                           rst,
   input  logic                           we,
   input  logic                           re,
   input  logic [$clog2(DEPTH_WORDS)-1:0] addr,
   input  logic [31:0]                    wdata,
   output logic [31:0]                    rdata
);

   logic [31:0] mem [DEPTH_WORDS];

   // Storage write; contents are intentionally never reset
   always_ff @(posedge clk) begin
      if (we) begin
         mem[addr] <= wdata;
      end
   end

   // Read register holds the last successful read until the next one
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         rdata <= '0;
      end else if (re) begin
         rdata <= mem[addr];
      end
   end

endmodule

// File: rtl/data_mem_ctrl.sv
// rtl/data_mem_ctrl.sv - wait-stated data-memory controller for the multicycle core
module data_mem_ctrl
   import dmem_pkg::*;
#(
   parameter logic [31:0] DATA_BASE   = 32'h10010000,
   parameter int          DEPTH_WORDS = 1024,
   parameter int          WAIT_CYCLES = 2
) (
   input  logic            clk,
   input  logic            rst,
   data_mem_ctrl_if.slave  bus
);

   localparam int          IDX_W = $clog2(DEPTH_WORDS);
   // Range limit in 33 bits so a window ending at the top of memory cannot wrap
   localparam logic [32:0] LIMIT = {1'b0, DATA_BASE} + (33'(DEPTH_WORDS) << ADDR_LSB);

   dmem_state_t      state, next_state;
   logic [3:0]       cnt;
   logic [IDX_W-1:0] lat_idx;
   logic [31:0]      lat_data;
   dmem_op_t         lat_op;
   logic             err_flag;

   logic             req;
   logic             in_range;
   logic             bad;
   logic [31:0]      offset;
   logic [IDX_W-1:0] idx;
   logic             ram_we;
   logic             ram_re;

   assign req      = bus.MemRead | bus.MemWrite;
   assign offset   = bus.dAddress - DATA_BASE;
   assign idx      = IDX_W'(offset >> ADDR_LSB);
   assign in_range = ({1'b0, bus.dAddress} >= {1'b0, DATA_BASE}) &&
                     ({1'b0, bus.dAddress} <  LIMIT);
   assign bad      = (bus.MemRead & bus.MemWrite) |
                     (bus.dAddress[ADDR_LSB-1:0] != '0) |
                     ~in_range;

   // State register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state <= IDLE;
      end else begin
         state <= next_state;
      end
   end

   // Next-state logic: rejected requests skip straight to DONE
   always_comb begin
      next_state = state;
      case (state)
         IDLE: begin
            if (req) begin
               if (bad) begin
                  next_state = DONE;
               end else if (WAIT_CYCLES > 0) begin
                  next_state = WAIT;
               end else begin
                  next_state = ACCESS;
               end
            end
         end
         WAIT: begin
            if (cnt == 4'd1) begin
               next_state = ACCESS;
            end
         end
         ACCESS:  next_state = DONE;
         DONE:    next_state = IDLE;
         default: next_state = IDLE;
      endcase
   end

   // Request latches and wait counter; inputs are only looked at in IDLE
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         cnt      <= '0;
         lat_idx  <= '0;
         lat_data <= '0;
         lat_op   <= OP_RD;
         err_flag <= 1'b0;
      end else if (state == IDLE && req) begin
         cnt      <= 4'(WAIT_CYCLES);
         lat_idx  <= idx;
         lat_data <= bus.dWriteData;
         lat_op   <= bus.MemWrite ? OP_WR : OP_RD;
         err_flag <= bad;
      end else if (state == WAIT) begin
         cnt      <= cnt - 4'd1;
      end
   end

   assign ram_we = (state == ACCESS) && (lat_op == OP_WR);
   assign ram_re = (state == ACCESS) && (lat_op == OP_RD);

   dmem_array #(
      .DEPTH_WORDS (DEPTH_WORDS)
   ) u_array (
      .clk   (clk),
      .rst   (rst),
      .we    (ram_we),
      .re    (ram_re),
      .addr  (lat_idx),
      .wdata (lat_data),
      .rdata (bus.dReadData)
   );

   assign bus.dReady = (state == DONE);
   assign bus.dError = (state == DONE) && err_flag;
   assign bus.dBusy  = (state != IDLE);

endmodule

// File: tb/tb_data_mem_ctrl.sv
// tb/tb_data_mem_ctrl.sv - directed bench for data_mem_ctrl at two wait settings
module tb_data_mem_ctrl;

   logic clk;
   logic rst_a;
   logic rst_b;
   int   checks;
   int   failures;

   data_mem_ctrl_if bus_a ();
   data_mem_ctrl_if bus_b ();

   data_mem_ctrl #(
      .DATA_BASE   (32'h10010000),
      .DEPTH_WORDS (1024),
      .WAIT_CYCLES (2)
   ) dut_a (
      .clk (clk),
      .rst (rst_a),
      .bus (bus_a)
   );

   data_mem_ctrl #(
      .DATA_BASE   (32'h10010000),
      .DEPTH_WORDS (1024),
      .WAIT_CYCLES (0)
   ) dut_b (
      .clk (clk),
      .rst (rst_b),
      .bus (bus_b)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
      end
   endtask

   task automatic drive(input bit sel_b, input bit rd, input bit wr,
                        input logic [31:0] addr, input logic [31:0] wdata);
      if (sel_b) begin
         bus_b.MemRead = rd; bus_b.MemWrite = wr;
         bus_b.dAddress = addr; bus_b.dWriteData = wdata;
      end else begin
         bus_a.MemRead = rd; bus_a.MemWrite = wr;
         bus_a.dAddress = addr; bus_a.dWriteData = wdata;
      end
   endtask

   // One access: strobes rise in cycle 0, dReady expected in cycle exp_lat
   task automatic acc(input bit sel_b, input bit rd, input bit wr,
                      input logic [31:0] addr, input logic [31:0] wdata,
                      input int exp_lat, input bit exp_err,
                      input bit chk_data, input logic [31:0] exp_data,
                      input string tag);
      int          lat;
      logic        rdy;
      logic        err_seen;
      logic [31:0] rdat;
      lat = -1;
      err_seen = 1'bx;
      rdat = 'x;
      @(posedge clk); #1;
      drive(sel_b, rd, wr, addr, wdata);
      for (int k = 1; k <= 30; k++) begin
         @(posedge clk); #1;
         rdy = sel_b ? bus_b.dReady : bus_a.dReady;
         if (rdy) begin
            lat      = k;
            err_seen = sel_b ? bus_b.dError : bus_a.dError;
            rdat     = sel_b ? bus_b.dReadData : bus_a.dReadData;
            break;
         end
      end
      drive(sel_b, 1'b0, 1'b0, 32'h0, 32'h0);
      chk({tag, "_latency"}, 32'(lat), 32'(exp_lat));
      chk({tag, "_err"}, {31'b0, err_seen}, {31'b0, exp_err});
      if (chk_data) chk({tag, "_data"}, rdat, exp_data);
      @(posedge clk); #1;
      chk({tag, "_pulse_end"},
          {30'b0, (sel_b ? bus_b.dReady : bus_a.dReady), (sel_b ? bus_b.dBusy : bus_a.dBusy)},
          32'h0);
   endtask

   initial begin
      checks   = 0;
      failures = 0;
      rst_a    = 1'b1;
      rst_b    = 1'b1;
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      drive(1'b1, 1'b0, 1'b0, 32'h0, 32'h0);
      repeat (3) @(posedge clk);
      #1;
      chk("rst_a_outs", {29'b0, bus_a.dReady, bus_a.dError, bus_a.dBusy}, 32'h0);
      chk("rst_a_rdata", bus_a.dReadData, 32'h0);
      chk("rst_b_outs", {29'b0, bus_b.dReady, bus_b.dError, bus_b.dBusy}, 32'h0);
      chk("rst_b_rdata", bus_b.dReadData, 32'h0);
      rst_a = 1'b0;
      rst_b = 1'b0;

      // W=2 write then read back
      acc(1'b0, 1'b0, 1'b1, 32'h10010004, 32'hDEADBEEF, 4, 1'b0, 1'b0, 32'h0, "t1_wr");
      acc(1'b0, 1'b1, 1'b0, 32'h10010004, 32'h0, 4, 1'b0, 1'b1, 32'hDEADBEEF, "t1_rd");

      // W=0 write then read back
      acc(1'b1, 1'b0, 1'b1, 32'h10010000, 32'h12345678, 2, 1'b0, 1'b0, 32'h0, "t2_wr");
      acc(1'b1, 1'b1, 1'b0, 32'h10010000, 32'h0, 2, 1'b0, 1'b1, 32'h12345678, "t2_rd");
      acc(1'b1, 1'b1, 1'b0, 32'h10010001, 32'h0, 1, 1'b1, 1'b1, 32'h12345678, "t2_mis");

      // Misaligned read leaves dReadData alone
      acc(1'b0, 1'b1, 1'b0, 32'h10010002, 32'h0, 1, 1'b1, 1'b1, 32'hDEADBEEF, "t3_mis");

      // Out-of-range writes around the window
      acc(1'b0, 1'b0, 1'b1, 32'h10010FFC, 32'hCAFEF00D, 4, 1'b0, 1'b0, 32'h0, "t4_last_wr");
      acc(1'b0, 1'b0, 1'b1, 32'h10011000, 32'h55555555, 1, 1'b1, 1'b0, 32'h0, "t4_top");
      acc(1'b0, 1'b0, 1'b1, 32'h0FFFFFFC, 32'h66666666, 1, 1'b1, 1'b0, 32'h0, "t4_below");
      acc(1'b0, 1'b0, 1'b1, 32'hFFFFFFFC, 32'h77777777, 1, 1'b1, 1'b0, 32'h0, "t4_wrap");
      acc(1'b0, 1'b1, 1'b0, 32'h10010FFC, 32'h0, 4, 1'b0, 1'b1, 32'hCAFEF00D, "t4_last_rd");

      // Read and write together is rejected and touches nothing
      acc(1'b0, 1'b1, 1'b1, 32'h10010004, 32'h0, 1, 1'b1, 1'b1, 32'hCAFEF00D, "t5_both");
      acc(1'b0, 1'b1, 1'b0, 32'h10010004, 32'h0, 4, 1'b0, 1'b1, 32'hDEADBEEF, "t5_rd");

      // Reset during WAIT of a write aborts it
      acc(1'b0, 1'b0, 1'b1, 32'h10010008, 32'h11111111, 4, 1'b0, 1'b0, 32'h0, "t6_pre");
      @(posedge clk); #1;
      drive(1'b0, 1'b0, 1'b1, 32'h10010008, 32'h99999999);
      @(posedge clk); #1;
      chk("t6_busy_wait", {31'b0, bus_a.dBusy}, 32'h1);
      #2;
      rst_a = 1'b1;
      #1;
      chk("t6_rst_outs", {29'b0, bus_a.dReady, bus_a.dError, bus_a.dBusy}, 32'h0);
      chk("t6_rst_rdata", bus_a.dReadData, 32'h0);
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
      @(posedge clk); #1;
      rst_a = 1'b0;
      chk("t6_busy_after", {31'b0, bus_a.dBusy}, 32'h0);
      acc(1'b0, 1'b1, 1'b0, 32'h10010008, 32'h0, 4, 1'b0, 1'b1, 32'h11111111, "t6_rd");

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
